// File: rtl/pixel_stream_adapter_if.sv
// ---------------------------------------------------------------------------
// pixel_stream_adapter_if
//   Upstream valid/ready pixel stream feeding pixel_stream_adapter.
//   s_data  : pixel value (DATA_W bits)
//   s_sof   : first pixel of a frame, qualified by s_valid
//   s_valid : beat valid (source -> sink)
//   s_ready : sink can accept a beat (sink -> source)
//   master  : pixel source side (framebuffer reader, DMA, image pipe)
//   slave   : pixel_stream_adapter side
// ---------------------------------------------------------------------------
interface pixel_stream_adapter_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] s_data;
  logic              s_sof;
  logic              s_valid;
  logic              s_ready;

  modport master (
    output s_data,
    output s_sof,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_sof,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/pixel_stream_adapter.sv
// ---------------------------------------------------------------------------
// pixel_stream_adapter
//   Elastic buffer between an upstream valid/ready pixel stream and a raster
//   display driver that pulls pixels by position. Locks the upstream
//   start-of-frame to the display frame origin, shows FILL_COLOR while
//   unlocked and resynchronises after underflow or frame misalignment.
//
// Ports:
//   clk           pixel clock
//   rstn          asynchronous active-low reset
//   up            upstream stream (slave modport: s_data/s_sof/s_valid/s_ready)
//   pixel_req     driver needs a pixel this cycle
//   pixel_hpos    column of the requested pixel
//   pixel_vpos    row of the requested pixel
//   pixel_data    pixel answering the previous-cycle request
//   pixel_valid   pixel_data valid (pixel_req delayed by one cycle)
//   locked        high while in RUN
//   underflow_cnt resync event count, saturating
//   fifo_level    current FIFO occupancy (0..FIFO_DEPTH)
// ---------------------------------------------------------------------------
module pixel_stream_adapter #(
  parameter int              DATA_W     = 24,
  parameter int              FIFO_DEPTH = 64,   // power of two, >= 4
  parameter logic [DATA_W-1:0] FILL_COLOR = '0
) (
  input  logic                          clk,
  input  logic                          rstn,
  pixel_stream_adapter_if.slave         up,
  input  logic                          pixel_req,
  input  logic [11:0]                   pixel_hpos,
  input  logic [11:0]                   pixel_vpos,
  output logic [DATA_W-1:0]             pixel_data,
  output logic                          pixel_valid,
  output logic                          locked,
  output logic [15:0]                   underflow_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Entry layout: {sof, data}
  logic [DATA_W:0]   mem [FIFO_DEPTH];
  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [LVL_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              full, empty;
  logic [DATA_W:0]   head;
  logic              head_sof;
  logic              wr_fire;
  logic              frame_origin;
  logic [PTR_W-1:0]  wr_addr;

  // FSM decisions
  logic              do_write;
  logic              pop;
  logic              clear;
  logic              cnt_inc;

  assign level        = wr_ptr - rd_ptr;
  assign full         = (level == LVL_W'(FIFO_DEPTH));
  assign empty        = (level == '0);
  assign head         = mem[rd_ptr[PTR_W-1:0]];
  assign head_sof     = head[DATA_W];
  assign frame_origin = pixel_req && (pixel_hpos == 12'd0) && (pixel_vpos == 12'd0);

  // FLUSH always accepts (and mostly discards); elsewhere back-pressure comes
  // from the registered level only, so a same-cycle pop never raises ready.
  assign up.s_ready   = rstn && ((state == FLUSH) || !full);
  assign wr_fire      = up.s_valid && up.s_ready;

  assign locked       = (state == RUN);
  assign fifo_level   = level;

  // A captured sof after a restart always lands in entry 0.
  assign wr_addr      = clear ? '0 : wr_ptr[PTR_W-1:0];

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    do_write  = 1'b0;
    pop       = 1'b0;
    clear     = 1'b0;
    cnt_inc   = 1'b0;

    unique case (state)
      FLUSH: begin
        if (wr_fire && up.s_sof) begin
          clear     = 1'b1;
          do_write  = 1'b1;
          state_nxt = ARMED;
        end
      end

      ARMED: begin
        do_write = wr_fire;
        if (frame_origin) begin
          pop       = 1'b1;
          state_nxt = RUN;
        end
      end

      RUN: begin
        if (pixel_req && (empty || (frame_origin != head_sof))) begin
          // Underflow, frame too long (origin without sof at head) or frame
          // too short (sof at head away from origin): drop everything.
          clear   = 1'b1;
          cnt_inc = 1'b1;
          if (wr_fire && up.s_sof) begin
            do_write  = 1'b1;
            state_nxt = ARMED;
          end else begin
            state_nxt = FLUSH;
          end
        end else begin
          do_write = wr_fire;
          pop      = pixel_req;
        end
      end

      default: state_nxt = FLUSH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= FLUSH;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      pixel_data    <= '0;
      pixel_valid   <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      state <= state_nxt;

      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= do_write ? LVL_W'(1) : '0;
      end else begin
        if (do_write) wr_ptr <= wr_ptr + 1'b1;
        if (pop)      rd_ptr <= rd_ptr + 1'b1;
      end

      pixel_valid <= pixel_req;
      if (pixel_req) begin
        pixel_data <= pop ? head[DATA_W-1:0] : FILL_COLOR;
      end

      if (cnt_inc && (underflow_cnt != 16'hFFFF)) begin
        underflow_cnt <= underflow_cnt + 16'd1;
      end
    end
  end

  // NOTE: the storage array has no reset; validity is tracked purely by the
  // pointers, which keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_addr] <= {up.s_sof, up.s_data};
    end
  end

endmodule

// File: doc/pixel_stream_adapter.md
Name: pixel_stream_adapter

Overview:
- Elastic buffer between an upstream valid/ready pixel stream (framebuffer reader, DMA, image pipe) and a raster display driver that pulls pixels by position.
- Runs in the display pixel clock domain and supplies the driver's pixel_data/pixel_valid inputs, replacing testpattern as the pixel source.
- Locks the upstream start-of-frame to the display frame origin, shows a fill colour while unlocked, and resynchronises automatically after underflow or frame misalignment.

Parameters:
- DATA_W, 24, pixel width (RGB888).
- FIFO_DEPTH, 64, FIFO entries; must be a power of two, minimum 4.
- FILL_COLOR, 24'h000000, pixel output while not in RUN or on underflow.

Ports:
- clk  in  1  pixel clock.
- rstn  in  1  reset, asynchronous, active-low.
- s_data  in  DATA_W  upstream pixel.
- s_sof  in  1  marks the first pixel of a frame; qualified by s_valid.
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  adapter can accept a beat.
- pixel_req  in  1  display driver needs a pixel this cycle (active-area strobe).
- pixel_hpos  in  12  display column of the requested pixel.
- pixel_vpos  in  12  display row of the requested pixel.
- pixel_data  out  DATA_W  pixel answering the previous-cycle request.
- pixel_valid  out  1  pixel_data valid.
- locked  out  1  high while state = RUN.
- underflow_cnt  out  16  count of resync events, saturating at 16'hFFFF.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is asynchronous and active-low on rstn. Reset values: state FLUSH, FIFO empty (pointers 0), pixel_data 0, pixel_valid 0, locked 0, underflow_cnt 0, fifo_level 0, s_ready 0 while rstn is low.
- FIFO stores {sof, data}, DATA_W+1 bits. Occupancy is FIFO_DEPTH+1 states (extra pointer bit).
- A write occurs on s_valid && s_ready. A read (pop) occurs only when the rules below say so. A simultaneous write and pop leaves the level unchanged.
- s_ready = 1 in FLUSH; otherwise s_ready = !full, using the registered level (a pop in the same cycle does not raise s_ready).
- frame_origin = pixel_req && pixel_hpos == 0 && pixel_vpos == 0.
- Output latency is exactly 1 cycle. pixel_valid(t+1) = pixel_req(t). pixel_data(t+1) is the popped FIFO data if a pop happened at t, else FILL_COLOR. With no request, pixel_data holds its last value.
- State FLUSH:
  - FIFO is held empty; beats without sof are accepted and discarded.
  - An accepted beat with sof: the FIFO restarts empty, the beat is written as entry 0, and the state goes to ARMED.
  - Requests are answered with FILL_COLOR.
- State ARMED:
  - Accepts writes; requests are answered with FILL_COLOR and do not pop.
  - On frame_origin the head (guaranteed sof) is popped, driven on the next cycle, and the state goes to RUN.
- State RUN:
  - Each pixel_req pops one entry.
  - Resync condition (any one of):
    - request with FIFO empty (underflow);
    - frame_origin while the head sof = 0 (upstream frame too long);
    - head sof = 1 popped on a request that is not frame_origin (upstream frame too short).
  - On resync: no pixel is consumed, FILL_COLOR is driven, underflow_cnt increments, the FIFO is cleared, and the state goes to FLUSH.
  - Exception: if the resync cycle also accepts a sof beat, that beat is captured and the state goes directly to ARMED.
- Writes arriving in a resync cycle that are not sof are discarded.
- Reset mid-operation: immediate return to the reset values; no FIFO content is retained.
- Widths: all counters wrap modulo 2^(pointer width) except underflow_cnt, which saturates.

Test Plan:
- FIFO_DEPTH=8, display 4x2: stream 8 pixels 0x000001..0x000008 (sof on the first), then issue 8 requests starting at (0,0) -> pixel_valid one cycle after each request; data sequence 01..08; locked goes 1 the cycle after the origin request; underflow_cnt stays 0.
- Requests while in FLUSH or ARMED -> pixel_data = FILL_COLOR (set 0x123456) with pixel_valid; fifo_level is unchanged by the requests.
- In RUN, stall upstream so the 5th request finds the FIFO empty -> 5th output = FILL_COLOR; underflow_cnt = 1; locked = 0; state FLUSH; the next sof beat returns to ARMED.
- Upstream sends a 7-pixel frame then a sof -> the sof head is popped at request 8 (not origin); a resync occurs; underflow_cnt increments; relock happens at the next origin.
- Fill the FIFO to 8 with no requests -> s_ready = 0; a request plus s_valid in the same cycle -> no write that cycle; level = 7 after it; s_ready = 1 the next cycle.
- Deassert rstn mid-frame with level 5 -> all outputs return to reset values immediately; after release, s_ready = 1 and the state is FLUSH.
